// File: rtl/hyperbus_delay_trainer.sv
// RWDS delay-line trainer: sweeps every tap, records a pass bitmap and centres delay_o in the
// longest passing window. Optional manual override is built when HYPERBUS_DELAY_MANUAL_EN is defined.
module hyperbus_delay_trainer #(
    parameter int NumTaps      = 16,
    parameter int TapWidth     = 4,
    parameter int SettleCycles = 8,
    parameter int NumTrials    = 4,
    parameter int DefaultDelay = 8
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                start_i,
`ifdef HYPERBUS_DELAY_MANUAL_EN
    input  logic                cfg_manual_i,
    input  logic [TapWidth-1:0] cfg_delay_i,
`endif
    output logic                busy_o,
    output logic                done_o,
    output logic                fail_o,
    output logic                test_req_o,
    input  logic                test_ack_i,
    input  logic                test_pass_i,
    output logic [TapWidth-1:0] delay_o,
    output logic [NumTaps-1:0]  pass_map_o,
    output logic [TapWidth:0]   win_len_o
);

    localparam int SetW = (SettleCycles > 1) ? $clog2(SettleCycles) : 1;
    localparam int TrW  = (NumTrials > 1) ? $clog2(NumTrials) : 1;
    localparam logic [TapWidth-1:0] LastTap  = TapWidth'(NumTaps - 1);
    localparam logic [SetW-1:0]     LastSet  = SetW'(SettleCycles - 1);
    localparam logic [TrW-1:0]      LastTry  = TrW'(NumTrials - 1);
    localparam logic [TapWidth:0]   LenOne   = (TapWidth+1)'(1);
    localparam logic [TapWidth:0]   LenZero  = (TapWidth+1)'(0);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SETTLE = 3'd1,
        TEST   = 3'd2,
        EVAL   = 3'd3,
        SCAN   = 3'd4,
        DONE   = 3'd5
    } state_t;

    state_t              state_r;
    logic [TapWidth-1:0] delay_r;
    logic [TapWidth-1:0] saved_delay_r;
    logic [SetW-1:0]     settle_cnt_r;
    logic [TrW-1:0]      trial_r;
    logic                tap_ok_r;
    logic [TapWidth-1:0] scan_idx_r;
    logic [TapWidth-1:0] cur_start_r;
    logic [TapWidth:0]   cur_len_r;
    logic [TapWidth-1:0] best_start_r;
    logic [TapWidth:0]   best_len_r;
    logic [TapWidth-1:0] fin_start_s;
    logic [TapWidth:0]   fin_len_s;
    logic                manual_s;

    // Floor centre of a window; the sum is formed one bit wider than a tap index.
    function automatic logic [TapWidth-1:0] centre_of(input logic [TapWidth-1:0] start,
                                                      input logic [TapWidth:0]   len);
        return TapWidth'({1'b0, start} + ((len - LenOne) >> 1));
    endfunction

`ifdef HYPERBUS_DELAY_MANUAL_EN
    assign manual_s = cfg_manual_i;
    assign delay_o  = cfg_manual_i ? cfg_delay_i : delay_r;
`else
    assign manual_s = 1'b0;
    assign delay_o  = delay_r;
`endif

    // Close a run that is still open at the end of the walk against the best run so far.
    always_comb begin
        fin_start_s = best_start_r;
        fin_len_s   = best_len_r;
        if (cur_len_r > best_len_r) begin
            fin_start_s = cur_start_r;
            fin_len_s   = cur_len_r;
        end else begin
            fin_start_s = best_start_r;
            fin_len_s   = best_len_r;
        end
    end

    // Training FSM with all outputs registered.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_r       <= IDLE;
            delay_r       <= TapWidth'(DefaultDelay);
            saved_delay_r <= TapWidth'(DefaultDelay);
            settle_cnt_r  <= '0;
            trial_r       <= '0;
            tap_ok_r      <= 1'b0;
            scan_idx_r    <= '0;
            cur_start_r   <= '0;
            cur_len_r     <= '0;
            best_start_r  <= '0;
            best_len_r    <= '0;
            busy_o        <= 1'b0;
            done_o        <= 1'b0;
            fail_o        <= 1'b0;
            test_req_o    <= 1'b0;
            pass_map_o    <= '0;
            win_len_o     <= '0;
        end else begin
            done_o <= 1'b0;
            if (manual_s && (state_r != IDLE)) begin
                // Override aborts quietly; the last trained delay stays in place underneath.
                state_r    <= IDLE;
                busy_o     <= 1'b0;
                test_req_o <= 1'b0;
                delay_r    <= saved_delay_r;
            end else begin
                case (state_r)
                    IDLE: begin
                        if (start_i && !manual_s) begin
                            state_r       <= SETTLE;
                            busy_o        <= 1'b1;
                            fail_o        <= 1'b0;
                            pass_map_o    <= '0;
                            saved_delay_r <= delay_r;
                            delay_r       <= '0;
                            settle_cnt_r  <= '0;
                        end
                    end
                    SETTLE: begin
                        if (settle_cnt_r == LastSet) begin
                            state_r    <= TEST;
                            trial_r    <= '0;
                            tap_ok_r   <= 1'b1;
                            test_req_o <= 1'b1;
                        end else begin
                            settle_cnt_r <= settle_cnt_r + SetW'(1);
                        end
                    end
                    TEST: begin
                        if (test_ack_i) begin
                            tap_ok_r <= tap_ok_r & test_pass_i;
                            if (trial_r == LastTry) begin
                                test_req_o <= 1'b0;
                                state_r    <= EVAL;
                            end else begin
                                trial_r <= trial_r + TrW'(1);
                            end
                        end
                    end
                    EVAL: begin
                        pass_map_o[delay_r] <= tap_ok_r;
                        if (delay_r == LastTap) begin
                            state_r      <= SCAN;
                            scan_idx_r   <= '0;
                            cur_start_r  <= '0;
                            cur_len_r    <= '0;
                            best_start_r <= '0;
                            best_len_r   <= '0;
                        end else begin
                            delay_r      <= delay_r + TapWidth'(1);
                            settle_cnt_r <= '0;
                            state_r      <= SETTLE;
                        end
                    end
                    SCAN: begin
                        // Strictly-longer replacement keeps the lowest-index window on ties.
                        if (pass_map_o[scan_idx_r]) begin
                            if (cur_len_r == LenZero) begin
                                cur_start_r <= scan_idx_r;
                            end
                            cur_len_r <= cur_len_r + LenOne;
                        end else begin
                            if (cur_len_r > best_len_r) begin
                                best_start_r <= cur_start_r;
                                best_len_r   <= cur_len_r;
                            end
                            cur_len_r <= '0;
                        end
                        if (scan_idx_r == LastTap) begin
                            busy_o  <= 1'b0;
                            state_r <= DONE;
                        end else begin
                            scan_idx_r <= scan_idx_r + TapWidth'(1);
                        end
                    end
                    DONE: begin
                        done_o  <= 1'b1;
                        state_r <= IDLE;
                        if (fin_len_s != LenZero) begin
                            delay_r   <= centre_of(fin_start_s, fin_len_s);
                            win_len_o <= fin_len_s;
                        end else begin
                            fail_o    <= 1'b1;
                            win_len_o <= '0;
                            delay_r   <= saved_delay_r;
                        end
                    end
                    default: begin
                        state_r    <= IDLE;
                        busy_o     <= 1'b0;
                        test_req_o <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule
